// File: rtl/display.sv
// Output stage of the ticket vending machine: captures an 8-bit value, splits it
// into three decimal digits and streams them as ASCII with leading-zero blanking.
module display #(
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter logic [7:0] ZERO_CHAR  = 8'h30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_RDY2,
    input  logic [7:0] DATA_in2,
    output logic       state_cmp2,
    output logic       out_RDY2,
    output logic [7:0] DATA_out2
);

    typedef enum logic [2:0] {
        IDLE,
        GET,
        CONV,
        S_H,
        S_T,
        S_U,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] value_q, value_d;
    logic [7:0] hund_q, hund_d;
    logic [7:0] tens_q, tens_d;
    logic [7:0] units_q, units_d;
    logic       rdy_q, rdy_d;
    logic       cmp_q, cmp_d;
    logic [7:0] char_q, char_d;
    logic [7:0] div10;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        units_d = units_q;
        rdy_d   = 1'b0;
        cmp_d   = 1'b0;
        char_d  = 8'h00;
        div10   = value_q / 8'd10;

        unique case (state_q)
            IDLE: begin
                if (in_RDY2) begin
                    state_d = GET;
                end
            end
            GET: begin
                value_d = DATA_in2;
                state_d = CONV;
            end
            CONV: begin
                hund_d  = value_q / 8'd100;
                tens_d  = div10 % 8'd10;
                units_d = value_q % 8'd10;
                state_d = S_H;
            end
            S_H: begin
                rdy_d   = 1'b1;
                char_d  = (hund_q == 8'd0) ? BLANK_CHAR : ZERO_CHAR + hund_q;
                state_d = S_T;
            end
            S_T: begin
                rdy_d   = 1'b1;
                // A zero tens digit is only a leading zero when hundreds is zero too.
                char_d  = (hund_q == 8'd0 && tens_q == 8'd0) ? BLANK_CHAR : ZERO_CHAR + tens_q;
                state_d = S_U;
            end
            S_U: begin
                rdy_d   = 1'b1;
                char_d  = ZERO_CHAR + units_q;
                state_d = DONE;
            end
            DONE: begin
                cmp_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            value_q <= 8'h00;
            hund_q  <= 8'h00;
            tens_q  <= 8'h00;
            units_q <= 8'h00;
            rdy_q   <= 1'b0;
            cmp_q   <= 1'b0;
            char_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            rdy_q   <= rdy_d;
            cmp_q   <= cmp_d;
            char_q  <= char_d;
        end
    end

    assign out_RDY2   = rdy_q;
    assign state_cmp2 = cmp_q;
    assign DATA_out2  = char_q;

endmodule

// File: tb/tb_display.sv
// Self-checking bench for display: a cycle-schedule model of the output stream
// compared every cycle, plus directed transactions with literal expectations.
module tb_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_RDY2;
    logic [7:0] DATA_in2;
    logic       state_cmp2;
    logic       out_RDY2;
    logic [7:0] DATA_out2;

    int n_checks = 0;
    int n_pass   = 0;

    display dut (
        .clk        (clk),
        .rst        (rst),
        .in_RDY2    (in_RDY2),
        .DATA_in2   (DATA_in2),
        .state_cmp2 (state_cmp2),
        .out_RDY2   (out_RDY2),
        .DATA_out2  (DATA_out2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Model: expected outputs per clock edge, scheduled from accepted requests.
    bit       exp_rdy  [0:1023];
    bit [7:0] exp_data [0:1023];
    bit       exp_cmp  [0:1023];
    int       cyc     = 0;
    int       free_at = 0;
    int       pend_at = -1;

    function automatic bit [7:0] digit_char(input int d, input bit blank);
        return blank ? 8'h20 : 8'(8'h30 + d);
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                exp_rdy[cyc + k]  = 1'b0;
                exp_data[cyc + k] = 8'h00;
                exp_cmp[cyc + k]  = 1'b0;
            end
            free_at = 0;
            pend_at = -1;
        end else begin
            if (cyc == pend_at) begin
                int v, h, t, u;
                v = int'(DATA_in2);
                h = v / 100;
                t = (v / 10) % 10;
                u = v % 10;
                exp_rdy[cyc + 2]  = 1'b1;
                exp_data[cyc + 2] = digit_char(h, h == 0);
                exp_rdy[cyc + 3]  = 1'b1;
                exp_data[cyc + 3] = digit_char(t, h == 0 && t == 0);
                exp_rdy[cyc + 4]  = 1'b1;
                exp_data[cyc + 4] = digit_char(u, 1'b0);
                exp_cmp[cyc + 5]  = 1'b1;
            end
            if (in_RDY2 && cyc >= free_at) begin
                free_at = cyc + 7;
                pend_at = cyc + 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("model out_RDY2", int'(out_RDY2), int'(exp_rdy[cyc]));
        check("model DATA_out2", int'(DATA_out2), int'(exp_data[cyc]));
        check("model state_cmp2", int'(state_cmp2), int'(exp_cmp[cyc]));
    end

    task automatic run_txn(input logic [7:0] v, input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input bit busy, input bit mid_rst);
        int         n_str = 0;
        int         n_cmp = 0;
        int         cmp_pos = -1;
        int         str_pos0 = -1;
        logic [7:0] got [3];
        for (int k = 0; k < 3; k++) got[k] = 8'h00;
        @(negedge clk) in_RDY2 = 1'b1;
        @(negedge clk);
        in_RDY2  = 1'b0;
        DATA_in2 = v;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) DATA_in2 = ~v;
            if (out_RDY2) begin
                if (n_str == 0) str_pos0 = i;
                if (n_str < 3) got[n_str] = DATA_out2;
                n_str++;
            end
            if (state_cmp2) begin
                cmp_pos = i;
                n_cmp++;
            end
            in_RDY2 = busy && (i == 1);
            if (mid_rst && i == 2) begin
                #2 rst = 1'b0;
                #1;
                check("async reset out_RDY2", int'(out_RDY2), 0);
                check("async reset DATA_out2", int'(DATA_out2), 0);
                check("async reset state_cmp2", int'(state_cmp2), 0);
            end
        end
        if (mid_rst) begin
            check("strobes before abort", n_str, 1);
            check("completions before abort", n_cmp, 0);
        end else begin
            check("strobe count", n_str, 3);
            check("completion count", n_cmp, 1);
            check("hundreds char", int'(got[0]), int'(c0));
            check("tens char", int'(got[1]), int'(c1));
            check("units char", int'(got[2]), int'(c2));
            check("first strobe slot", str_pos0, 2);
            check("completion slot", cmp_pos, 5);
        end
    endtask

    initial begin
        int n_str, n_cmp, cmp2_pos;
        rst      = 1'b0;
        in_RDY2  = 1'b0;
        DATA_in2 = 8'h00;
        @(posedge clk);
        #1;
        check("reset out_RDY2", int'(out_RDY2), 0);
        check("reset state_cmp2", int'(state_cmp2), 0);
        check("reset DATA_out2", int'(DATA_out2), 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;

        n_str = 0;
        n_cmp = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_RDY2) n_str++;
            if (state_cmp2) n_cmp++;
        end
        check("idle strobes", n_str, 0);
        check("idle completions", n_cmp, 0);

        run_txn(8'd5,   8'h20, 8'h20, 8'h35, 1'b0, 1'b0);
        run_txn(8'd10,  8'h20, 8'h31, 8'h30, 1'b0, 1'b0);
        run_txn(8'd255, 8'h32, 8'h35, 8'h35, 1'b0, 1'b0);
        run_txn(8'd0,   8'h20, 8'h20, 8'h30, 1'b0, 1'b0);
        run_txn(8'd100, 8'h31, 8'h30, 8'h30, 1'b0, 1'b0);
        run_txn(8'd7,   8'h20, 8'h20, 8'h37, 1'b1, 1'b0);

        // in_RDY2 held high: a new transaction starts every 7 cycles.
        @(negedge clk);
        in_RDY2  = 1'b1;
        DATA_in2 = 8'd42;
        n_str    = 0;
        n_cmp    = 0;
        cmp2_pos = -1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (out_RDY2) n_str++;
            if (state_cmp2) begin
                n_cmp++;
                if (n_cmp == 2) cmp2_pos = i;
            end
        end
        in_RDY2 = 1'b0;
        check("held strobes", n_str, 6);
        check("held completions", n_cmp, 2);
        check("second completion slot", cmp2_pos, 13);
        repeat (10) @(posedge clk);

        run_txn(8'd123, 8'h31, 8'h32, 8'h33, 1'b0, 1'b1);
        @(negedge clk) rst = 1'b1;
        n_str = 0;
        n_cmp = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_RDY2) n_str++;
            if (state_cmp2) n_cmp++;
        end
        check("strobes after abort", n_str, 0);
        check("completions after abort", n_cmp, 0);

        run_txn(8'd99, 8'h20, 8'h39, 8'h39, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
